// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode constants and format codes for the ID-stage immediate generator.
package imm_gen_pipe_pkg;

    localparam logic [6:0] R_TYPE      = 7'b0110011;
    localparam logic [6:0] I_TYPE      = 7'b0010011;
    localparam logic [6:0] LOAD_TYPE   = 7'b0000011;
    localparam logic [6:0] STORE_TYPE  = 7'b0100011;
    localparam logic [6:0] BRANCH_TYPE = 7'b1100011;
    localparam logic [6:0] JALR_TYPE   = 7'b1100111;
    localparam logic [6:0] LUI_TYPE    = 7'b0110111;
    localparam logic [6:0] AUIPC_TYPE  = 7'b0010111;
    localparam logic [6:0] JAL_TYPE    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decoder: opcode -> format, sign-extended immediate, illegal flag.
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          SHIFT_BJ = 1'b1
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    fmt_e fmt;

    always_comb begin
        imm_o     = '0;
        fmt       = FMT_NONE;
        illegal_o = 1'b0;
        case (instr_i[6:0])
            I_TYPE, LOAD_TYPE, JALR_TYPE: begin
                fmt   = FMT_I;
                imm_o = XLEN'($signed(instr_i[31:20]));
            end
            STORE_TYPE: begin
                fmt   = FMT_S;
                imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
            end
            BRANCH_TYPE: begin
                fmt = FMT_B;
                if (SHIFT_BJ)
                    imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                           instr_i[11:8], 1'b0}));
                else
                    imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                           instr_i[11:8]}));
            end
            LUI_TYPE, AUIPC_TYPE: begin
                fmt   = FMT_U;
                imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
            end
            JAL_TYPE: begin
                fmt = FMT_J;
                if (SHIFT_BJ)
                    imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                           instr_i[30:21], 1'b0}));
                else
                    imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                           instr_i[30:21]}));
            end
            R_TYPE: fmt = FMT_NONE;
            default: illegal_o = 1'b1;
        endcase
    end

    assign fmt_o = fmt;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decoder at the input, output register plus one
// skid entry so ready_o is purely registered and the stream never drops a result.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          SHIFT_BJ = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;

    imm_decode #(
        .XLEN    (XLEN),
        .SHIFT_BJ(SHIFT_BJ)
    ) u_decode (
        .instr_i  (instr_i),
        .imm_o    (dec_imm),
        .fmt_o    (dec_fmt),
        .illegal_o(dec_ill)
    );

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q,   out_imm_d;
    logic [2:0]      out_fmt_q,   out_fmt_d;
    logic            out_ill_q,   out_ill_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,  skid_imm_d;
    logic [2:0]      skid_fmt_q,  skid_fmt_d;
    logic            skid_ill_q,  skid_ill_d;

    logic accept;
    logic fire;

    assign accept = valid_i & ~skid_valid_q;
    assign fire   = out_valid_q & ready_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_ill_d   = skid_ill_q;
        // A full skid entry implies ready_o=0, so no accept can coincide with its drain.
        if (!out_valid_q || fire) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_fmt_d    = skid_fmt_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_fmt_d   = dec_fmt;
                out_ill_d   = dec_ill;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
            skid_ill_d   = dec_ill;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign ready_o   = ~skid_valid_q;
    assign valid_o   = out_valid_q;
    assign imm_o     = out_imm_q;
    assign fmt_o     = out_fmt_q;
    assign illegal_o = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: two DUT configurations share one stimulus stream and are
// checked against an arithmetic reference model of the immediate encodings.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [31:0] instr_i = '0;

    logic        ready_a, valid_a, ill_a;
    logic [31:0] imm_a;
    logic [2:0]  fmt_a;
    logic        ready_b, valid_b, ill_b;
    logic [63:0] imm_b;
    logic [2:0]  fmt_b;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SHIFT_BJ(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_a),
        .instr_i(instr_i), .valid_o(valid_a), .ready_i(ready_i),
        .imm_o(imm_a), .fmt_o(fmt_a), .illegal_o(ill_a)
    );

    imm_gen_pipe #(.XLEN(64), .SHIFT_BJ(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_b),
        .instr_i(instr_i), .valid_o(valid_b), .ready_i(ready_i),
        .imm_o(imm_b), .fmt_o(fmt_b), .illegal_o(ill_b)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: field values as signed integers, scaled, then truncated to XLEN.
    function automatic exp_t model(input logic [31:0] ins, input int xlen, input bit sh);
        exp_t   e;
        longint v;
        v     = 0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin
                v = longint'($signed(ins[31:20])); e.fmt = 3'd1;
            end
            7'h23: begin
                v = longint'($signed({ins[31:25], ins[11:7]})); e.fmt = 3'd2;
            end
            7'h63: begin
                v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]}));
                if (sh) v = v * 2;
                e.fmt = 3'd3;
            end
            7'h37, 7'h17: begin
                v = longint'($signed(ins[31:12])) * 4096; e.fmt = 3'd4;
            end
            7'h6F: begin
                v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]}));
                if (sh) v = v * 2;
                e.fmt = 3'd5;
            end
            7'h33: e.fmt = 3'd0;
            default: e.ill = 1'b1;
        endcase
        if (xlen == 32) e.imm = {32'h0, v[31:0]};
        else            e.imm = v;
        return e;
    endfunction

    // Monitor first (pops results presented this cycle), then capture accepted inputs.
    always @(negedge clk) begin
        exp_t e;
        if (rst_i) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (valid_a && ready_i) begin
                if (q_a.size() == 0) check("a_unexpected_output", 64'd1, 64'd0);
                else begin
                    e = q_a.pop_front();
                    check("a_imm", {32'h0, imm_a}, e.imm);
                    check("a_fmt", {61'h0, fmt_a}, {61'h0, e.fmt});
                    check("a_ill", {63'h0, ill_a}, {63'h0, e.ill});
                end
            end
            if (valid_b && ready_i) begin
                if (q_b.size() == 0) check("b_unexpected_output", 64'd1, 64'd0);
                else begin
                    e = q_b.pop_front();
                    check("b_imm", imm_b, e.imm);
                    check("b_fmt", {61'h0, fmt_b}, {61'h0, e.fmt});
                    check("b_ill", {63'h0, ill_b}, {63'h0, e.ill});
                end
            end
            if (valid_i && ready_a) q_a.push_back(model(instr_i, 32, 1'b1));
            if (valid_i && ready_b) q_b.push_back(model(instr_i, 64, 1'b0));
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic rdy);
        @(posedge clk);
        #1;
        valid_i = v;
        instr_i = ins;
        ready_i = rdy;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_valid_a", {63'h0, valid_a}, 64'd0);
        check("rst_ready_a", {63'h0, ready_a}, 64'd1);
        check("rst_imm_a",   {32'h0, imm_a},   64'd0);
        check("rst_fmt_a",   {61'h0, fmt_a},   64'd0);
        check("rst_ill_a",   {63'h0, ill_a},   64'd0);
        check("rst_valid_b", {63'h0, valid_b}, 64'd0);
        check("rst_ready_b", {63'h0, ready_b}, 64'd1);
    endtask

    logic [31:0] directed [12] = '{
        32'hFFF00093, 32'hFE112E23, 32'h123450B7, 32'hFE000CE3,
        32'h0010006F, 32'h0000007F, 32'h002081B3, 32'h80002283,
        32'h7FF08067, 32'h80000517, 32'h7E000FE3, 32'h8000006F
    };
    logic [6:0] ops [10] = '{
        7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0B
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned drain;
        logic [31:0] r;

        do_reset();

        foreach (directed[i]) drive(1'b1, directed[i], 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        check("valid_drops_a", {63'h0, valid_a}, 64'd0);

        // Stall: two accepted, third held off until the consumer drains.
        drive(1'b1, 32'hFFF00093, 1'b0);
        drive(1'b1, 32'h123450B7, 1'b0);
        drive(1'b1, 32'hFE000CE3, 1'b0);
        @(negedge clk);
        check("stall_ready_a", {63'h0, ready_a}, 64'd0);
        repeat (3) drive(1'b1, 32'hFE000CE3, 1'b0);
        @(negedge clk);
        check("stall_hold_ready_a", {63'h0, ready_a}, 64'd0);
        check("stall_hold_valid_a", {63'h0, valid_a}, 64'd1);
        check("stall_hold_imm_a",   {32'h0, imm_a},   64'hFFFFFFFF);
        drive(1'b0, '0, 1'b1);
        repeat (3) drive(1'b0, '0, 1'b1);

        // Reset with output and skid both occupied.
        drive(1'b1, 32'hFE112E23, 1'b0);
        drive(1'b1, 32'h0010006F, 1'b0);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        check("full_ready_a", {63'h0, ready_a}, 64'd0);
        do_reset();
        drive(1'b1, 32'h0010006F, 1'b1);
        drive(1'b0, '0, 1'b1);

        for (int unsigned n = 0; n < 3000; n++) begin
            r = $urandom;
            if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 9)];
            drive(($urandom_range(0, 9) < 7), r, ($urandom_range(0, 9) < 6));
        end

        drain = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && drain < 20) begin
            drive(1'b0, '0, 1'b1);
            drain++;
        end
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        check("drain_q_a", 64'(q_a.size()), 64'd0);
        check("drain_q_b", 64'(q_b.size()), 64'd0);
        check("drain_valid_a", {63'h0, valid_a}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
